instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/fetch_cache.sv | 45 ++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared ISA definitions, address widths and fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    // ISA: the opcode lives in the top nibble of the high instruction byte
    localparam int         OPC_W    = 4;
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_JUMP = 4'h1;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_HI   = 2'd1,
        FETCH_LO   = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_cache.sv
// ============================================================================
// Module      : fetch_cache
// Description : One-entry instruction cache (tag, data, valid); only built
//               when FETCH_CACHE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef FETCH_CACHE_EN
module fetch_cache
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  lookup_addr,
    output logic               lookup_hit,
    output logic [INSTR_W-1:0] lookup_data,
    input  logic               fill_en,
    input  logic [ADDR_W-1:0]  fill_addr,
    input  logic [INSTR_W-1:0] fill_data
);

    logic               r_valid;
    logic [ADDR_W-1:0]  r_tag;
    logic [INSTR_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= fill_addr;
            r_data  <= fill_data;
        end
    end

    assign lookup_hit  = r_valid && (r_tag == lookup_addr);
    assign lookup_data = r_data;

endmodule
`endif

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Two-byte instruction fetch from byte-wide program memory.
//               Optional one-entry cache enabled by macro FETCH_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  program_counter,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [BYTE_W-1:0]  mem_rdata,
    output logic               misaligned
);

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic [INSTR_W-1:0] r_instr;
    logic               r_misaligned;
    logic [ADDR_W-1:0]  w_pc_aligned;
    logic               w_hi_done;
    logic               w_lo_done;
    logic               w_hit;
    logic [INSTR_W-1:0] w_hit_data;

    assign w_pc_aligned = align_addr(program_counter);

`ifdef FETCH_CACHE_EN
    fetch_cache u_fetch_cache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (w_pc_aligned),
        .lookup_hit  (w_hit),
        .lookup_data (w_hit_data),
        .fill_en     (w_lo_done),
        .fill_addr   (r_fetch_addr),
        .fill_data   ({r_instr[INSTR_W-1:BYTE_W], mem_rdata})
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory outputs decode straight from the state so an ack arriving in the
    // first cycle of a fetch state is taken without a wait cycle.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_addr    = r_fetch_addr;
        instr_valid = 1'b0;
        w_hi_done   = 1'b0;
        w_lo_done   = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                w_state_nxt = w_hit ? FETCH_HOLD : FETCH_HI;
            end
            FETCH_HI: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_hi_done   = 1'b1;
                    w_state_nxt = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = r_fetch_addr + c_addr_one;
                if (mem_ack) begin
                    w_lo_done   = 1'b1;
                    w_state_nxt = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_state_nxt = FETCH_IDLE;
                end
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_addr <= '0;
            r_instr      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (r_state == FETCH_IDLE) begin
                r_fetch_addr <= w_pc_aligned;
                if (program_counter[0]) begin
                    r_misaligned <= 1'b1;
                end
                if (w_hit) begin
                    r_instr <= w_hit_data;
                end
            end
            if (w_hi_done) begin
                r_instr[INSTR_W-1:BYTE_W] <= mem_rdata;
            end
            if (w_lo_done) begin
                r_instr[BYTE_W-1:0] <= mem_rdata;
            end
        end
    end

    assign instruction = r_instr;
    assign misaligned  = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;
    import instr_fetch_pkg::*;

`ifdef FETCH_CACHE_EN
    localparam bit c_has_cache = 1'b1;
`else
    localparam bit c_has_cache = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] program_counter;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        misaligned;

    logic        drv_ack;
    logic [7:0]  drv_rdata;
    logic        force_ack;
    int          ack_delay;
    int          wait_cnt;
    logic [7:0]  mem [0:4095];

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .program_counter (program_counter),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack   = force_ack | drv_ack;
    assign mem_rdata = force_ack ? 8'hEE : drv_rdata;

    // Memory answers after ack_delay wait cycles; counting restarts per byte.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                drv_ack   <= 1'b1;
                drv_rdata <= mem[mem_addr];
                wait_cnt  <= 0;
            end else begin
                drv_ack  <= 1'b0;
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            drv_ack  <= 1'b0;
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] pc;
        int          delay;
        bit          wiggle;
        logic [15:0] exp_instr;
        logic [11:0] exp_hi;
        bit          exp_mis;
    } vec_t;

    // Starts in IDLE at a negedge; returns at the negedge where instr_valid is seen.
    task automatic do_fetch(input logic [11:0] pc, input int d, input bit wiggle,
                            input logic [15:0] exp_instr, input logic [11:0] exp_hi,
                            input bit exp_mis, input bit exp_hit);
        logic [11:0] trace[$];
        logic [11:0] exp_addr;
        int          cyc;
        int          n_exp;
        bit          got;
        ack_delay       = d;
        program_counter = pc;
        cyc             = 0;
        got             = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (wiggle) program_counter = 12'($urandom);
            if (mem_req) trace.push_back(mem_addr);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("valid_timeout", 32'(got), 32'd1);
        if (!got) return;
        n_exp = exp_hit ? 0 : 2 * (d + 1);
        chk("latency", 32'(cyc), 32'(n_exp + 1));
        chk("req_cycles", 32'(trace.size()), 32'(n_exp));
        for (int i = 0; i < trace.size() && i < n_exp; i++) begin
            exp_addr = (i < d + 1) ? exp_hi : exp_hi + 12'd1;
            chk("mem_addr", 32'(trace[i]), 32'(exp_addr));
        end
        chk("instruction", 32'(instruction), 32'(exp_instr));
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
    endtask

    task automatic handshake();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("valid_after_hs", 32'(instr_valid), 32'd0);
        chk("req_after_hs", 32'(mem_req), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, 32'(instruction), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mis"}, 32'(misaligned), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   got;

        vecs[0] = '{12'hFFE, 0, 1'b0, 16'h5AC3, 12'hFFE, 1'b0};
        vecs[1] = '{12'h040, 3, 1'b1, 16'h1234, 12'h040, 1'b0};
        vecs[2] = '{12'h005, 0, 1'b0, 16'h7788, 12'h004, 1'b1};
        vecs[3] = '{12'h000, 1, 1'b0, 16'hA123, 12'h000, 1'b1};
        vecs[4] = '{12'hFFF, 2, 1'b0, 16'h5AC3, 12'hFFE, 1'b1};

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'hA1; mem[12'h001] = 8'h23;
        mem[12'hFFE] = 8'h5A; mem[12'hFFF] = 8'hC3;
        mem[12'h004] = 8'h77; mem[12'h005] = 8'h88;
        mem[12'h040] = 8'h12; mem[12'h041] = 8'h34;
        mem[12'h020] = 8'hBE; mem[12'h021] = 8'hEF;
        mem[12'h010] = {OPC_JUMP, 4'h0}; mem[12'h011] = 8'h10;

        rst             = 1'b0;
        instr_ready     = 1'b0;
        program_counter = 12'h000;
        force_ack       = 1'b0;
        ack_delay       = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // First fetch after release, then hold with instr_ready low
        rst = 1'b1;
        do_fetch(12'h000, 0, 1'b0, 16'hA123, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_instr", 32'(instruction), 32'hA123);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_req", 32'(mem_req), 32'd0);
        end
        handshake();

        for (int v = 0; v < 5; v++) begin
            do_fetch(vecs[v].pc, vecs[v].delay, vecs[v].wiggle, vecs[v].exp_instr,
                     vecs[v].exp_hi, vecs[v].exp_mis, 1'b0);
            handshake();
        end

        // Reset while waiting in FETCH_LO, then a stray ack right after release
        ack_delay       = 3;
        program_counter = 12'h040;
        got             = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 12'h041) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach_lo", 32'(got), 32'd1);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        ack_delay       = 0;
        program_counter = 12'h020;
        force_ack       = 1'b1;
        rst             = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        chk("stray_req", 32'(mem_req), 32'd1);
        chk("stray_addr", 32'(mem_addr), 32'h020);
        chk("stray_instr", 32'(instruction), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("post_rst_valid", 32'(got), 32'd1);
        chk("post_rst_instr", 32'(instruction), 32'hBEEF);
        handshake();

        // Jump-to-self loop: second fetch hits the cache only when it is built
        do_fetch(12'h010, 0, 1'b0, 16'h1010, 12'h010, 1'b0, 1'b0);
        handshake();
        do_fetch(12'h010, 0, 1'b0, 16'h1010, 12'h010, 1'b0, c_has_cache);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
